// File: rtl/mc_core_ctrl.sv
// mc_core_ctrl: multicycle MIPS-subset core (lw, sw, beq, addi, j, add/sub/and/or/slt).
// Instruction register, register file, A/B/ALUOut/MDR and the control FSM share one block.
// Memory handshake: the request stays stable until mem_ready; reset aborts any pending request.
module mc_core_ctrl #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] pc_o,
    output logic              instr_done,
    output logic              halted
);
    localparam int NREG = 1 << REG_AW;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
        S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP, S_HALT
    } state_e;

    state_e            state_q;
    logic [DATA_W-1:0] pc_q;
    logic [31:0]       ir_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] alu_q;
    logic [DATA_W-1:0] mdr_q;
    logic [DATA_W-1:0] regs_q [NREG];

    logic [5:0]        opcode_s;
    logic [5:0]        funct_s;
    logic [REG_AW-1:0] rs_s;
    logic [REG_AW-1:0] rt_s;
    logic [REG_AW-1:0] rd_s;
    logic [DATA_W-1:0] simm_s;
    logic [DATA_W-1:0] rs_val_s;
    logic [DATA_W-1:0] rt_val_s;
    logic [DATA_W-1:0] alu_res_s;
    logic              alu_ok_s;

    // Register-number fields are truncated to the register-file address width.
    assign opcode_s = ir_q[31:26];
    assign funct_s  = ir_q[5:0];
    assign rs_s     = ir_q[21 +: REG_AW];
    assign rt_s     = ir_q[16 +: REG_AW];
    assign rd_s     = ir_q[11 +: REG_AW];
    assign simm_s   = {{(DATA_W-16){ir_q[15]}}, ir_q[15:0]};
    assign rs_val_s = (rs_s == '0) ? '0 : regs_q[rs_s];
    assign rt_val_s = (rt_s == '0) ? '0 : regs_q[rt_s];
    assign pc_o     = pc_q;

    // R-type ALU; alu_ok_s drops for an unsupported funct so EXEC can halt.
    always_comb begin
        alu_res_s = '0;
        alu_ok_s  = 1'b1;
        case (funct_s)
            FN_ADD:  alu_res_s = a_q + b_q;
            FN_SUB:  alu_res_s = a_q - b_q;
            FN_AND:  alu_res_s = a_q & b_q;
            FN_OR:   alu_res_s = a_q | b_q;
            FN_SLT:  alu_res_s = ($signed(a_q) < $signed(b_q)) ? {{(DATA_W-1){1'b0}}, 1'b1} : '0;
            default: alu_ok_s  = 1'b0;
        endcase
    end

    // Control FSM and datapath registers; memory states wait for mem_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (mem_ready) begin
                        ir_q    <= mem_rdata[31:0];
                        pc_q    <= pc_q + DATA_W'(4);
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a_q   <= rs_val_s;
                    b_q   <= rt_val_s;
                    alu_q <= pc_q + (simm_s << 2);
                    case (opcode_s)
                        OP_RTYPE:     state_q <= S_EXEC;
                        OP_LW, OP_SW: state_q <= S_MEMADR;
                        OP_BEQ:       state_q <= S_BRANCH;
                        OP_ADDI:      state_q <= S_ADDIEX;
                        OP_J:         state_q <= S_JUMP;
                        default:      state_q <= S_HALT;
                    endcase
                end
                S_MEMADR: begin
                    alu_q   <= a_q + simm_s;
                    state_q <= (opcode_s == OP_LW) ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    if (mem_ready) begin
                        mdr_q   <= mem_rdata;
                        state_q <= S_MEMWB;
                    end
                end
                S_MEMWB: begin
                    if (rt_s != '0) regs_q[rt_s] <= mdr_q;
                    state_q <= S_FETCH;
                end
                S_MEMWR: begin
                    if (mem_ready) state_q <= S_FETCH;
                end
                S_EXEC: begin
                    if (alu_ok_s) begin
                        alu_q   <= alu_res_s;
                        state_q <= S_ALUWB;
                    end else begin
                        state_q <= S_HALT;
                    end
                end
                S_ALUWB: begin
                    if (rd_s != '0) regs_q[rd_s] <= alu_q;
                    state_q <= S_FETCH;
                end
                S_ADDIEX: begin
                    alu_q   <= a_q + simm_s;
                    state_q <= S_ADDIWB;
                end
                S_ADDIWB: begin
                    if (rt_s != '0) regs_q[rt_s] <= alu_q;
                    state_q <= S_FETCH;
                end
                S_BRANCH: begin
                    if (a_q == b_q) pc_q <= alu_q;
                    state_q <= S_FETCH;
                end
                S_JUMP: begin
                    pc_q    <= {pc_q[DATA_W-1:28], ir_q[25:0], 2'b00};
                    state_q <= S_FETCH;
                end
                S_HALT:  state_q <= S_HALT;
                default: state_q <= S_HALT;
            endcase
        end
    end

    // Bus and status outputs decoded from the state register; reset forces the bus idle.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = alu_q;
        mem_wdata  = b_q;
        instr_done = 1'b0;
        halted     = 1'b0;
        if (rst) begin
            mem_req = 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    mem_req  = 1'b1;
                    mem_addr = pc_q;
                end
                S_MEMRD: mem_req = 1'b1;
                S_MEMWR: begin
                    mem_req    = 1'b1;
                    mem_we     = 1'b1;
                    instr_done = mem_ready;
                end
                S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: instr_done = 1'b1;
                S_HALT:  halted = 1'b1;
                default: mem_req = 1'b0;
            endcase
        end
    end
endmodule
